// File: rtl/kbd_char_encoder_pkg.sv
// Shared definitions for the keyboard character encoder: FIFO depth default,
// ASCII control codes, the RUN/LOCKED state type and the key-index helper.
package kbd_char_encoder_pkg;

    localparam int DEPTH_DEFAULT = 8;
    localparam int KEYS_W        = 128;
    localparam int CODE_W        = 7;

    localparam logic [CODE_W-1:0] ASCII_NUL   = 7'h00;
    localparam logic [CODE_W-1:0] ASCII_ETX   = 7'h03;
    localparam logic [CODE_W-1:0] ASCII_LF    = 7'h0A;
    localparam logic [CODE_W-1:0] ASCII_SPACE = 7'h20;
    localparam logic [CODE_W-1:0] ASCII_DEL   = 7'h7F;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Index of the highest set bit; only meaningful when the vector is one-hot.
    function automatic logic [CODE_W-1:0] onehot_index(input logic [KEYS_W-1:0] v);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < KEYS_W; i++) begin
            if (v[i]) idx = i[CODE_W-1:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// First-word-fall-through character FIFO (DEPTH x 7) with flush, occupancy
// count and full/empty flags. The head reads as zero while empty.
module kbd_fifo
    import kbd_char_encoder_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [CODE_W-1:0] din,
    output logic [CODE_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count
);

    logic [CODE_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
    assign dout  = empty ? '0 : mem[rd_ptr_q];

    // A push into a full FIFO is allowed only when the head leaves the same cycle.
    always_comb begin
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/kbd_char_encoder.sv
// Converts one-hot key lines into ASCII codes queued in a FIFO, with edge
// detection, multi-key/overflow flags and a lock that engages once ETX is queued.
module kbd_char_encoder
    import kbd_char_encoder_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [KEYS_W-1:0]        Keys,
    input  logic                     Clear,
    output logic [CODE_W-1:0]        CharData,
    output logic                     CharValid,
    input  logic                     CharReady,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Overflow,
    output logic                     MultiKey,
    output logic                     EtxSeen
);

    logic [KEYS_W-1:0] keys_q, keys_d;
    state_t            state_q, state_d;
    logic              overflow_q, overflow_d;
    logic              multi_key_q, multi_key_d;
    logic              etx_seen_q, etx_seen_d;

    logic              keys_zero;
    logic              keys_onehot;
    logic              key_event;
    logic [CODE_W-1:0] key_code;
    logic              accept;
    logic              pop_fire;
    logic              push_fire;
    logic              drop;
    logic              fifo_empty;
    logic              fifo_full;

    assign CharValid = !fifo_empty;
    assign Overflow  = overflow_q;
    assign MultiKey  = multi_key_q;
    assign EtxSeen   = etx_seen_q;

    // Event detection: exactly one key high and the vector differs from last cycle.
    always_comb begin
        keys_zero   = (Keys == '0);
        keys_onehot = !keys_zero && ((Keys & (Keys - KEYS_W'(1))) == '0);
        key_event   = keys_onehot && (Keys != keys_q);
        key_code    = onehot_index(Keys);
        accept      = key_event && (state_q == ST_RUN);
        pop_fire    = CharValid && CharReady;
        push_fire   = accept && (!fifo_full || pop_fire) && !Clear;
        drop        = accept && fifo_full && !pop_fire;
    end

    always_comb begin
        keys_d      = Keys;
        state_d     = state_q;
        overflow_d  = overflow_q | drop;
        multi_key_d = multi_key_q | (!keys_zero && !keys_onehot);
        etx_seen_d  = etx_seen_q;
        if (push_fire && key_code == ASCII_ETX) begin
            state_d    = ST_LOCKED;
            etx_seen_d = 1'b1;
        end
        if (Clear) begin
            state_d     = ST_RUN;
            overflow_d  = 1'b0;
            multi_key_d = 1'b0;
            etx_seen_d  = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            keys_q      <= '0;
            state_q     <= ST_RUN;
            overflow_q  <= 1'b0;
            multi_key_q <= 1'b0;
            etx_seen_q  <= 1'b0;
        end else begin
            keys_q      <= keys_d;
            state_q     <= state_d;
            overflow_q  <= overflow_d;
            multi_key_q <= multi_key_d;
            etx_seen_q  <= etx_seen_d;
        end
    end

    kbd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (Clk),
        .rst_n (Rst),
        .flush (Clear),
        .push  (push_fire),
        .pop   (pop_fire),
        .din   (key_code),
        .dout  (CharData),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (Count)
    );

endmodule

// File: doc/kbd_char_encoder.md
KBD_CHAR_ENCODER -- requirements
Module: kbd_char_encoder

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; power of two, range 2..32.
REQ-002 Clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Rst  in  1  reset; asynchronous assert, active-low (Rst=0 resets).
REQ-004 Keys  in  128  key lines; bit i high = key for ASCII code i (bit0 null ... bit3 etx, bit10 lf, bit32 space, bit127 del).
REQ-005 Clear  in  1  synchronous flush of FIFO and flags.
REQ-006 CharData  out  7  ASCII code at FIFO head.
REQ-007 CharValid  out  1  FIFO non-empty; CharData valid.
REQ-008 CharReady  in  1  consumer accepts head when CharValid=1.
REQ-009 Count  out  clog2(DEPTH)+1  current FIFO occupancy.
REQ-010 Overflow  out  1  sticky: a key event was dropped because the FIFO was full.
REQ-011 MultiKey  out  1  sticky: more than one key line was high in a sampled cycle.
REQ-012 EtxSeen  out  1  sticky: etx (0x03) has been enqueued; input locked.

Function
REQ-013 KeysQ SHALL register Keys every cycle, regardless of state.
REQ-014 Key event SHALL be Keys exactly one-hot AND Keys != KeysQ; key held for N cycles yields one event.
REQ-015 A direct one-hot-to-one-hot change (e.g. a->b with no idle cycle) SHALL be an event.
REQ-016 The same key repeated SHALL require an intervening cycle with a different vector (all-zero or another key).
REQ-017 Keys all-zero SHALL produce no event and no flag.
REQ-018 Popcount(Keys)>1 SHALL produce no event and SHALL set MultiKey.
REQ-019 Event code SHALL be the index of the high bit, 7 bits.
REQ-020 Event in RUN with FIFO not full SHALL push at that edge; CharValid rises the next cycle (1-cycle latency).
REQ-021 FIFO SHALL be first-word-fall-through; pop when CharValid && CharReady.
REQ-022 Event with FIFO full and no pop SHALL be dropped and set Overflow; FIFO contents unchanged.
REQ-023 Simultaneous push and pop SHALL both succeed, including when full; Count unchanged.
REQ-024 CharReady with FIFO empty SHALL have no effect.
REQ-025 States: RUN (events accepted) and LOCKED (events ignored, pops still served).
REQ-026 RUN->LOCKED when the etx code is pushed; EtxSeen set same edge. Dropped etx (full) SHALL NOT lock.
REQ-027 LOCKED->RUN only via Clear or reset.
REQ-028 Clear SHALL empty FIFO, zero Count, clear Overflow/MultiKey/EtxSeen, enter RUN; it overrides push and pop in the same cycle; KeysQ still loads.
REQ-029 Count SHALL equal pushes minus pops since last flush; read/write pointers wrap modulo DEPTH.

Reset
REQ-030 Rst=0 SHALL asynchronously force: state RUN, KeysQ=0, pointers 0, Count=0, CharValid=0, CharData=0, Overflow=0, MultiKey=0, EtxSeen=0.
REQ-031 Reset mid-operation SHALL discard all queued characters; first edge after release SHALL treat any held key as a new event (KeysQ=0).

Structure
REQ-032 Shared package SHALL hold DEPTH default and ASCII constants NUL=0x00, ETX=0x03, LF=0x0A, SPACE=0x20, DEL=0x7F.
REQ-033 FIFO storage and pointers SHALL be one sub-module, kbd_fifo (DEPTH x 7, FWFT, push/pop/flush, full/empty/count).
REQ-034 Encoder, popcount check, edge detect and RUN/LOCKED FSM SHALL live in kbd_char_encoder.

Verification
REQ-035 Type "div" then lf, one key per cycle, CharReady=1 -> CharData sequence 0x64,0x69,0x76,0x0A, each CharValid for exactly one cycle.
REQ-036 Hold 's' (bit 0x73) 2 cycles then 'i', CharReady=0 -> Count=2, queue 0x73,0x69.
REQ-037 CharReady=0, 9 distinct keys with DEPTH=8 -> Count=8, Overflow=1, 9th char absent; then one pop + one new key same cycle -> Count stays 8.
REQ-038 Keys with bits 0x61 and 0x62 both high -> MultiKey=1, Count unchanged.
REQ-039 Push etx, then key 'a' -> EtxSeen=1, 'a' ignored; Clear -> Count=0, EtxSeen=0, next 'a' queued as 0x61.
REQ-040 Rst=0 asynchronously with Count=3 -> Count=0, CharValid=0 immediately; held 'x' after release -> 0x78 queued once.
